matmul_result_streamer: RTL
===========================

Name: matmul_result_streamer

Overview:
Output-side companion to the matmul core. It captures the packed 4-lane result vector `x` from the matmul with a valid/ready handshake and buffers it. It then streams the vector out one 16-bit word per beat, lane 0 first, toward the host/file-writer side. This is the reverse of the word-by-word loading that feeds `a`/`b`, and it decouples matmul throughput from downstream backpressure.

Parameters:
- WIDTH, 16, bit width of one element/word
- LANES, 4, elements per result vector
- DEPTH, 2, number of whole vectors buffered; power of two, >= 1

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  matmul result vector present on in_vec
- in_ready  output  1  streamer can accept a vector this cycle
- in_vec  input  LANES*WIDTH  packed result; lane i = bits [i*WIDTH +: WIDTH]
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  downstream accepts the word this cycle
- out_data  output  WIDTH  current word
- out_idx  output  clog2(LANES)  lane index of current word
- out_last  output  1  current word is lane LANES-1
- frame_cnt  output  16  count of fully emitted vectors, wraps 0xFFFF->0

Behaviour:
- Storage: circular buffer of DEPTH vector slots with wr_ptr, rd_ptr, count (0..DEPTH), and a word pointer wptr (0..LANES-1) inside the head slot.
- Reset (async assert, sync-to-clock deassert is the system's job): count=0, pointers=0, wptr=0, frame_cnt=0. While rst is high: in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
- in_ready = (count < DEPTH), derived only from registered state. There is no combinational path from out_ready. When full, in_ready stays 0 even if the last word pops in the same cycle.
- Accept = in_valid & in_ready: write in_vec to slot[wr_ptr], wr_ptr++ (mod DEPTH).
- out_valid = (count != 0). out_data = slot[rd_ptr] lane wptr. out_idx = wptr. out_last = out_valid & (wptr == LANES-1). When empty, out_data=0 and out_idx=0.
- Beat = out_valid & out_ready. On a non-last beat, wptr++. On a last beat: wptr=0, rd_ptr++, frame_cnt++.
- Count update: count += accept − (last beat). Simultaneous accept and last beat leaves count unchanged.
- Latency: a vector accepted at edge N drives its lane 0 from cycle N+1 when the buffer was empty. There is no same-cycle bypass.
- Throughput: LANES cycles per vector with out_ready held high. No bubble between back-to-back vectors.
- Backpressure: while out_ready=0, out_data, out_idx, out_last and out_valid hold stable. in_vec sampled into a slot is never altered by later in_vec changes.
- in_valid while in_ready=0 has no effect; the upstream holds the vector.
- Asserting rst mid-vector discards all buffered vectors and any partial emission. After release, streaming restarts from lane 0 of the next accepted vector.

Optional Feature:
Macro MATMUL_STREAM_PARITY_EN.
- Defined: adds output `out_parity` (1 bit) = XOR reduction of out_data (even parity over the word), 0 when out_valid=0 and during reset.
- Undefined: the port does not exist, and there is no parity logic.

Test Plan:
- Single vector: in_vec lanes {0x0001,0x0002,0x0003,0x0004}, out_ready=1.
  - Words 0x0001..0x0004 on cycles N+1..N+4.
  - out_idx 0..3; out_last only with 0x0004.
  - frame_cnt=1.
- Backpressure: same vector, out_ready=0 for 3 cycles after the 2nd word. 0x0003/out_idx=2 held stable for 3 cycles, then emission resumes. Total output is 4 words, no duplicates.
- Full: out_ready=0, offer 3 vectors (A,B,C).
  - in_ready falls after A,B are accepted.
  - Release out_ready: A's 4 words, then B's 4 words with no gap.
  - in_ready returns one cycle after A's last beat; C is then accepted.
- Simultaneous: count=DEPTH-1, new vector accepted on the same edge as a last beat. count is unchanged, and the next head word is lane 0 of the following vector.
- Reset mid-vector: assert rst after 2 words of a vector. Outputs go to 0 immediately. After release, out_valid=0 until a new vector 0xAAAA..; its first word is 0xAAAA with out_idx=0, and frame_cnt=0.
- Parity (MATMUL_STREAM_PARITY_EN): words 0x0001, 0x0003, 0xFFFF, 0x8000 give out_parity 1, 0, 0, 1. Preload frame_cnt via 65536 vectors, or force it, to check wrap to 0.

Source files
------------

// File: rtl/matmul_result_streamer.sv
// matmul_result_streamer
// Buffers whole result vectors from the matmul core and streams each one out
// as single WIDTH-bit words, lane 0 first. The buffer holds DEPTH vectors.
// in_ready depends only on registered state, so out_ready never reaches it.
// Optional feature macro: MATMUL_STREAM_PARITY_EN adds out_parity, the even
// parity (XOR reduction) of out_data.
module matmul_result_streamer #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [(LANES > 1 ? $clog2(LANES) : 1)-1:0] out_idx,
  output logic                     out_last,
  output logic [15:0]              frame_cnt
`ifdef MATMUL_STREAM_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][LANES*WIDTH-1:0] slot_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IDXW-1:0] wptr_q, wptr_d;
  logic [15:0]     frame_q, frame_d;

  logic                        accept, beat, last_beat, head_last;
  logic [LANES-1:0][WIDTH-1:0] head_lanes;

  // Slot pointers wrap at DEPTH; DEPTH=1 keeps them pinned at zero.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake and head-of-buffer view. Gating with rst keeps every output at
  // zero while reset is held, independent of what the state registers hold.
  assign head_lanes = slot_q[rd_ptr_q];
  assign head_last  = (wptr_q == IDXW'(LANES - 1));
  assign in_ready   = ~rst & (count_q < CW'(DEPTH));
  assign out_valid  = ~rst & (count_q != '0);
  assign out_data   = out_valid ? head_lanes[wptr_q] : '0;
  assign out_idx    = out_valid ? wptr_q : '0;
  assign out_last   = out_valid & head_last;
  assign frame_cnt  = frame_q;

  assign accept     = in_valid & in_ready;
  assign beat       = out_valid & out_ready;
  assign last_beat  = beat & head_last;

`ifdef MATMUL_STREAM_PARITY_EN
  // out_data is already zero when nothing is valid, so parity follows suit.
  assign out_parity = ^out_data;
`endif

  // Next-state for pointers, occupancy and the emitted-frame counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    frame_d  = frame_q;
    if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (beat) begin
      if (head_last) begin
        wptr_d   = '0;
        rd_ptr_d = ptr_inc(rd_ptr_q);
        frame_d  = frame_q + 16'd1;
      end else begin
        wptr_d = wptr_q + IDXW'(1);
      end
    end
    // An accept and a last beat on the same edge cancel out.
    unique case ({accept, last_beat})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      frame_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      frame_q  <= frame_d;
    end
  end

  // Vector storage: a slot is written only on accept, so later in_vec changes
  // cannot disturb a captured vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (accept) begin
      slot_q[wr_ptr_q] <= in_vec;
    end
  end

endmodule
